// File: rtl/fetch_queue.sv
// fetch_queue: instruction-fetch stage between the PC register and decode.
// It keeps at most one instruction-memory request outstanding, buffers the
// returned {pc, instr, exc} entries in a DEPTH-entry FIFO, and presents the
// head entry to decode with a valid/ready handshake. pc_en lets the upstream
// PC advance only in a cycle where a fetch is issued.
// Optional build macro FETCH_ALIGN_CHECK_EN: when defined, a misaligned pc_in
// is not fetched. Instead, a single exception entry is queued for it.
module fetch_queue #(
  parameter int          DEPTH    = 2,
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc_in,
  output logic        pc_en,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_instr,
  output logic        out_exc
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT, DROP} state_t;

  state_t        state_q;
  logic [CW-1:0] count_q;
  logic [AW-1:0] wptr_q, rptr_q;
  logic [31:0]   addr_q;
  logic [31:0]   pc_mem    [DEPTH];
  logic [31:0]   instr_mem [DEPTH];

  logic        has_space;
  logic        issue;
  logic        exc_push;
  logic        push;
  logic        pop;
  logic [31:0] push_pc;
  logic [31:0] push_instr;

  assign has_space = (count_q < DEPTH_C);

`ifdef FETCH_ALIGN_CHECK_EN
  logic        misalign;
  logic        exc_lock_q;
  logic [31:0] exc_pc_q;
  logic        exc_mem [DEPTH];

  // A misaligned PC is never sent to memory. It yields one exception entry
  // until a flush redirects the PC.
  assign misalign = (pc_in[1:0] != 2'b00);
  assign issue    = (state_q == IDLE) && !reset && !flush && has_space && !misalign;
  assign exc_push = (state_q == IDLE) && !reset && !flush && has_space && misalign &&
                    !(exc_lock_q && (exc_pc_q == pc_in));

  // Remember that an exception for this PC is already queued.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      exc_lock_q <= 1'b0;
    end else if (exc_push) begin
      exc_lock_q <= 1'b1;
      exc_pc_q   <= pc_in;
    end
  end

  // Exception flag storage travels with the pc/instr storage.
  always_ff @(posedge clk) begin
    if (push) exc_mem[wptr_q] <= exc_push;
  end

  assign out_exc = out_valid ? exc_mem[rptr_q] : 1'b0;
`else
  assign issue    = (state_q == IDLE) && !reset && !flush && has_space;
  assign exc_push = 1'b0;
  assign out_exc  = 1'b0;
`endif

  assign imem_req  = issue;
  assign imem_addr = pc_in;
  assign pc_en     = issue;

  // Issue is gated on count < DEPTH, so a response always has a free slot.
  assign push       = ((state_q == WAIT) && imem_rvalid && !flush) || exc_push;
  assign push_pc    = exc_push ? pc_in : addr_q;
  assign push_instr = exc_push ? 32'h0 : imem_rdata;
  assign pop        = out_valid && out_ready && !flush;

  // Request sequencing: IDLE issues, WAIT collects, DROP swallows a flushed response.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      case (state_q)
        IDLE: if (issue) state_q <= WAIT;
        WAIT: begin
          if (imem_rvalid)  state_q <= IDLE;
          else if (flush)   state_q <= DROP;
        end
        DROP: if (imem_rvalid) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Latch the request address so the response can be tagged with its PC.
  always_ff @(posedge clk) begin
    if (issue) addr_q <= pc_in;
  end

  // FIFO pointers and occupancy. A flush empties the queue and ignores that cycle's pop.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      count_q <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop)  rptr_q <= rptr_q + 1'b1;
      count_q <= count_q + CW'(push) - CW'(pop);
    end
  end

  // FIFO storage. Entries are valid only while counted, so no reset is needed.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wptr_q]    <= push_pc;
      instr_mem[wptr_q] <= push_instr;
    end
  end

  assign out_valid = (count_q != '0);
  assign out_pc    = out_valid ? pc_mem[rptr_q]    : 32'h0;
  assign out_instr = out_valid ? instr_mem[rptr_q] : 32'h0;

`ifndef SYNTHESIS
  logic armed_q;
  logic rst_seen_q;

  // Track the first cycle after reset and whether a request has been issued since.
  always_ff @(posedge clk) begin
    if (reset) begin
      armed_q    <= 1'b0;
      rst_seen_q <= 1'b1;
    end else begin
      rst_seen_q <= 1'b0;
      if (issue) armed_q <= 1'b1;
    end
  end

  // Protocol and occupancy sanity checks.
  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (!(armed_q && (state_q == IDLE) && imem_rvalid));
      assert (count_q <= DEPTH_C);
      assert (!rst_seen_q || (pc_in == RESET_PC));
    end
  end
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: randomized and directed checks of fetch_queue against a
// queue-based reference model, a variable-latency memory model and an
// upstream PC model.
module tb_fetch_queue;
  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc_in;
  logic        pc_en;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic        out_exc;

  fetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'h0000_3000)) dut (
    .clk(clk), .reset(reset), .pc_in(pc_in), .pc_en(pc_en),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rvalid(imem_rvalid),
    .imem_rdata(imem_rdata), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .out_pc(out_pc), .out_instr(out_instr), .out_exc(out_exc)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] pc; logic [31:0] instr; } ent_t;
  ent_t q[$];

  int total = 0;
  int bad   = 0;

  // memory / upstream model state
  bit          mem_out = 0;
  int          mem_rem = 0;
  int          mem_lat = 0;
  logic [31:0] mem_addr, mem_data;
  bit          dropped = 0;
  bit          force_en = 0;
  logic [31:0] force_data = 32'hDEADBEEF;
  logic [31:0] pc_m = 32'h3000;

  // per-cycle observed / expected values
  logic        o_req, o_pc_en, o_valid, o_exc;
  logic [31:0] o_addr, o_pc, o_instr;
  logic        e_req, e_valid;
  logic [31:0] e_pc, e_instr, e_addr;

  // One clock cycle: drive inputs, sample at negedge, advance the model.
  task automatic step(input bit fl, input bit rdy, input logic [31:0] redir);
    bit   rv;
    bit   do_push;
    ent_t ent;
    flush     = fl;
    out_ready = rdy;
    pc_in     = pc_m;
    rv = mem_out && (mem_rem == 1);
    imem_rvalid = rv;
    imem_rdata  = rv ? mem_data : $urandom;
    if (mem_out && !rv) mem_rem--;
    @(negedge clk);
    e_req   = !mem_out && !fl && (q.size() < DEPTH);
    e_valid = (q.size() != 0);
    e_pc    = e_valid ? q[0].pc : 32'h0;
    e_instr = e_valid ? q[0].instr : 32'h0;
    e_addr  = pc_m;
    o_req = imem_req; o_pc_en = pc_en; o_valid = out_valid; o_exc = out_exc;
    o_addr = imem_addr; o_pc = out_pc; o_instr = out_instr;
    do_push = 0;
    if (rv) begin
      mem_out = 0;
      if (!fl && !dropped) begin do_push = 1; ent = '{mem_addr, mem_data}; end
      dropped = 0;
    end
    if (fl && mem_out) dropped = 1;
    if (e_valid && rdy && !fl) void'(q.pop_front());
    if (do_push) q.push_back(ent);
    if (fl) q.delete();
    if (o_req) begin
      mem_out  = 1;
      mem_addr = o_addr;
      mem_data = force_en ? force_data : $urandom;
      mem_rem  = (mem_lat != 0) ? mem_lat : int'($urandom_range(1, 3));
    end
    if (fl) pc_m = redir;
    else if (o_pc_en) pc_m = pc_m + 32'd4;
    @(posedge clk); #1;
  endtask

  // Flush repeatedly until no request is outstanding.
  task automatic drain(input bit rdy, input logic [31:0] redir);
    int n = 0;
    step(1'b1, rdy, redir);
    while (mem_out && n < 10) begin step(1'b1, rdy, redir); n++; end
    total++; if (mem_out) begin bad++; $display("FAIL drain_timeout: outstanding=%0b want 0", mem_out); end
  endtask

  task automatic test_reset();
    reset = 1'b1; flush = 1'b0; out_ready = 1'b0; imem_rvalid = 1'b0;
    imem_rdata = 32'h0; pc_in = 32'h3000;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++; if (imem_req  !== 1'b0)  begin bad++; $display("FAIL rst_req: got %b want 0", imem_req); end
    total++; if (pc_en     !== 1'b0)  begin bad++; $display("FAIL rst_pc_en: got %b want 0", pc_en); end
    total++; if (out_valid !== 1'b0)  begin bad++; $display("FAIL rst_valid: got %b want 0", out_valid); end
    total++; if (out_pc    !== 32'h0) begin bad++; $display("FAIL rst_out_pc: got %h want 0", out_pc); end
    total++; if (out_exc   !== 1'b0)  begin bad++; $display("FAIL rst_exc: got %b want 0", out_exc); end
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_basic();
    int pulses = 0;
    mem_lat = 1;
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b1, 32'h0);
      pulses += int'(o_pc_en);
      if (i == 0) begin
        total++; if (o_req !== 1'b1) begin bad++; $display("FAIL basic_first_req: got %b want 1", o_req); end
        total++; if (o_addr !== 32'h3000) begin bad++; $display("FAIL basic_first_addr: got %h want 3000", o_addr); end
      end
      if (i == 2) begin
        total++; if (o_valid !== 1'b1) begin bad++; $display("FAIL basic_valid_c2: got %b want 1", o_valid); end
        total++; if (o_pc !== 32'h3000) begin bad++; $display("FAIL basic_pc_c2: got %h want 3000", o_pc); end
      end
      total++; if (o_req !== e_req) begin bad++; $display("FAIL basic_req c%0d: got %b want %b", i, o_req, e_req); end
      total++; if (o_instr !== e_instr) begin bad++; $display("FAIL basic_instr c%0d: got %h want %h", i, o_instr, e_instr); end
    end
    total++; if (pulses !== 4) begin bad++; $display("FAIL basic_pc_en_pulses: got %0d want 4", pulses); end
  endtask

  task automatic test_backpressure();
    drain(1'b0, 32'h4000);
    mem_lat = 3;
    for (int i = 0; i < 14; i++) begin
      step(1'b0, 1'b0, 32'h0);
      total++; if (o_req !== e_req) begin bad++; $display("FAIL bp_req c%0d: got %b want %b", i, o_req, e_req); end
      total++; if (o_pc !== e_pc) begin bad++; $display("FAIL bp_pc c%0d: got %h want %h", i, o_pc, e_pc); end
    end
    total++; if (o_req !== 1'b0 || o_pc_en !== 1'b0) begin bad++; $display("FAIL bp_full_stall: req=%b pc_en=%b want 0 0", o_req, o_pc_en); end
    total++; if (o_pc !== 32'h4000) begin bad++; $display("FAIL bp_head: got %h want 4000", o_pc); end
    step(1'b0, 1'b1, 32'h0);
    total++; if (o_pc !== 32'h4000 || o_req !== 1'b0) begin bad++; $display("FAIL bp_rel1: pc=%h req=%b want 4000 0", o_pc, o_req); end
    step(1'b0, 1'b1, 32'h0);
    total++; if (o_pc !== 32'h4004) begin bad++; $display("FAIL bp_second: got %h want 4004", o_pc); end
    total++; if (o_req !== 1'b1 || o_addr !== 32'h4008) begin bad++; $display("FAIL bp_resume: req=%b addr=%h want 1 4008", o_req, o_addr); end
  endtask

  task automatic test_flush_wait();
    drain(1'b1, 32'h5000);
    mem_lat = 2; force_en = 1;
    step(1'b0, 1'b1, 32'h0);
    total++; if (o_req !== 1'b1 || o_addr !== 32'h5000) begin bad++; $display("FAIL fw_issue: req=%b addr=%h want 1 5000", o_req, o_addr); end
    force_en = 0;
    step(1'b1, 1'b1, 32'h3100);
    total++; if (o_req !== 1'b0 || o_pc_en !== 1'b0) begin bad++; $display("FAIL fw_flush_cycle: req=%b pc_en=%b want 0 0", o_req, o_pc_en); end
    step(1'b0, 1'b1, 32'h0);
    total++; if (o_req !== 1'b0) begin bad++; $display("FAIL fw_drop_rvalid_req: got %b want 0", o_req); end
    step(1'b0, 1'b1, 32'h0);
    total++; if (o_req !== 1'b1 || o_addr !== 32'h3100) begin bad++; $display("FAIL fw_reissue: req=%b addr=%h want 1 3100", o_req, o_addr); end
    total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL fw_no_stale: valid=%b want 0", o_valid); end
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b1, 32'h0);
      total++; if (o_instr === 32'hDEADBEEF || o_instr !== e_instr) begin bad++; $display("FAIL fw_instr c%0d: got %h want %h", i, o_instr, e_instr); end
    end
  endtask

  task automatic test_flush_rvalid();
    drain(1'b0, 32'h6000);
    mem_lat = 1;
    step(1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 32'h0);
    total++; if (o_valid !== 1'b1 || o_pc !== 32'h6000) begin bad++; $display("FAIL fr_setup: valid=%b pc=%h want 1 6000", o_valid, o_pc); end
    step(1'b1, 1'b1, 32'h7000);
    step(1'b0, 1'b0, 32'h0);
    total++; if (o_valid !== 1'b0 || o_pc !== 32'h0) begin bad++; $display("FAIL fr_cleared: valid=%b pc=%h want 0 0", o_valid, o_pc); end
    total++; if (o_req !== 1'b1 || o_addr !== 32'h7000) begin bad++; $display("FAIL fr_idle_issue: req=%b addr=%h want 1 7000", o_req, o_addr); end
  endtask

  task automatic test_back_to_back();
    step(1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 32'h0);
    total++; if (o_pc !== 32'h7000 || o_req !== 1'b1) begin bad++; $display("FAIL bb_setup: pc=%h req=%b want 7000 1", o_pc, o_req); end
    step(1'b0, 1'b1, 32'h0);
    step(1'b0, 1'b0, 32'h0);
    total++; if (o_valid !== 1'b1 || o_pc !== 32'h7004) begin bad++; $display("FAIL bb_head_adv: valid=%b pc=%h want 1 7004", o_valid, o_pc); end
    total++; if (o_req !== 1'b1) begin bad++; $display("FAIL bb_count1_issue: req=%b want 1", o_req); end
  endtask

  task automatic test_random();
    bit fl, rdy;
    mem_lat = 0;
    for (int i = 0; i < 400; i++) begin
      fl  = ($urandom_range(0, 15) == 0);
      rdy = $urandom_range(0, 1) != 0;
      step(fl, rdy, $urandom & 32'hFFFF_FFFC);
      total++; if (o_req !== e_req) begin bad++; $display("FAIL rnd_req c%0d: got %b want %b", i, o_req, e_req); end
      total++; if (o_pc_en !== e_req) begin bad++; $display("FAIL rnd_pc_en c%0d: got %b want %b", i, o_pc_en, e_req); end
      total++; if (o_valid !== e_valid) begin bad++; $display("FAIL rnd_valid c%0d: got %b want %b", i, o_valid, e_valid); end
      total++; if (o_pc !== e_pc) begin bad++; $display("FAIL rnd_pc c%0d: got %h want %h", i, o_pc, e_pc); end
      total++; if (o_instr !== e_instr) begin bad++; $display("FAIL rnd_instr c%0d: got %h want %h", i, o_instr, e_instr); end
      total++; if (o_exc !== 1'b0) begin bad++; $display("FAIL rnd_exc c%0d: got %b want 0", i, o_exc); end
      if (e_req) begin
        total++; if (o_addr !== e_addr) begin bad++; $display("FAIL rnd_addr c%0d: got %h want %h", i, o_addr, e_addr); end
      end
    end
  endtask

  task automatic test_align();
    drain(1'b0, 32'h3002);
    step(1'b0, 1'b0, 32'h0);
`ifdef FETCH_ALIGN_CHECK_EN
    total++; if (o_req !== 1'b0 || o_pc_en !== 1'b0) begin bad++; $display("FAIL al_no_req: req=%b pc_en=%b want 0 0", o_req, o_pc_en); end
    step(1'b0, 1'b0, 32'h0);
    total++; if (o_valid !== 1'b1 || o_exc !== 1'b1) begin bad++; $display("FAIL al_exc: valid=%b exc=%b want 1 1", o_valid, o_exc); end
    total++; if (o_pc !== 32'h3002 || o_instr !== 32'h0) begin bad++; $display("FAIL al_entry: pc=%h instr=%h want 3002 0", o_pc, o_instr); end
`else
    total++; if (o_req !== 1'b1 || o_addr !== 32'h3002) begin bad++; $display("FAIL al_plain: req=%b addr=%h want 1 3002", o_req, o_addr); end
`endif
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: sim time exceeded");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_flush_wait();
    test_flush_rvalid();
    test_back_to_back();
    test_random();
    test_align();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Instruction-fetch stage directly downstream of the PC register.
- Takes the current PC, issues single-outstanding requests to a variable-latency instruction memory, and buffers returned {pc, instr} pairs in a small FIFO.
- Presents buffered pairs to decode with a valid/ready handshake.
- Drives pc_en back to the NPC/PC path so the PC advances only when a fetch is accepted.

Parameters:
- DEPTH, 2, FIFO entries (power of two, >= 2).
- RESET_PC, 32'h00003000, PC value expected on pc_in after reset; informational, used only by assertions.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- pc_in  input  32  current PC from PC register
- pc_en  output  1  PC may advance this cycle; upstream holds PC when 0
- imem_req  output  1  fetch request; memory samples imem_addr at the clk edge where imem_req=1
- imem_addr  output  32  fetch address
- imem_rvalid  input  1  response valid; at least 1 cycle after request, exactly one per request
- imem_rdata  input  32  instruction word, valid with imem_rvalid
- flush  input  1  redirect; discard queued and in-flight fetches
- out_valid  output  1  head entry valid
- out_ready  input  1  decode accepts head
- out_pc  output  32  PC of head entry; 0 when out_valid=0
- out_instr  output  32  instruction of head entry; 0 when out_valid=0
- out_exc  output  1  head entry is a fetch exception (see Optional Feature); 0 when out_valid=0

Behaviour:
- Single clock, synchronous active-high reset.
- Reset: state=IDLE, count=0, FIFO pointers=0, out_valid=0, imem_req=0, pc_en=0. Reset overrides flush and any in-flight response. A response arriving after reset is ignored while in IDLE.
- State machine: IDLE, WAIT, DROP.
- IDLE:
  - imem_req = !reset && !flush && count < DEPTH.
  - imem_addr = pc_in; pc_en = imem_req (combinational).
  - Captures pc_in into addr_reg at the issue edge, then moves to WAIT.
- WAIT:
  - imem_req=0, pc_en=0.
  - On imem_rvalid: push {addr_reg, imem_rdata, exc=0} and go to IDLE. No new issue in the same cycle, so minimum fetch period is 2 cycles.
- Space reservation: issue requires count < DEPTH. Pops only lower count, so a push in WAIT never overflows.
- FIFO: pop when out_valid && out_ready. Push and pop in the same cycle leave count unchanged. Pointers wrap modulo DEPTH. out_valid = (count != 0).
- Head data is registered FIFO storage. A pushed entry is visible on outputs the cycle after the rvalid edge, giving 1-cycle response-to-decode latency.
- Flush (highest priority after reset):
  - Next cycle count=0 and pointers=0; the pop that cycle is ignored.
  - imem_req=0 and pc_en=0 during the flush cycle. Upstream loads the redirect target regardless of pc_en.
  - In WAIT: rvalid in the same cycle → data discarded, go to IDLE; no rvalid → go to DROP.
  - In IDLE: stay IDLE.
  - In DROP: no state change.
- DROP: imem_req=0, pc_en=0. On imem_rvalid, discard data and go to IDLE. A flush while in DROP stays in DROP.
- imem_rvalid in IDLE (no outstanding request) is ignored.
- Assertion (sim only): imem_rvalid never seen in IDLE after reset; count never exceeds DEPTH.

Optional Feature:
- Macro FETCH_ALIGN_CHECK_EN.
- Defined: in IDLE with pc_in[1:0] != 0 and count < DEPTH:
  - imem_req=0 and pc_en=0.
  - Next cycle pushes {pc_in, 32'h0, exc=1} directly; state stays IDLE.
  - Only one exception entry per misaligned PC: the condition is not re-pushed while an exc entry for the same pc_in is queued. Upstream is expected to redirect via flush.
- Undefined: pc_in[1:0] is ignored for checking, imem_addr = pc_in unchanged, out_exc tied 0.

Test Plan:
- Reset, pc_in=32'h3000, memory latency 1, out_ready=1 → imem_req at cycle 0, rvalid cycle 1, out_valid cycle 2 with out_pc=32'h3000; pc_en pulses once per 2 cycles.
- out_ready=0, latency 3, pc_in sequence 3000,3004,3008 → exactly 2 entries queued (3000,3004); imem_req stays 0 with count=2 and pc_en=0; releasing out_ready resumes fetch of 3008.
- Flush while WAIT, rvalid 2 cycles later with rdata=32'hDEADBEEF → DROP entered, data never appears on out_*, next request issues the cycle after rvalid with the new pc_in=32'h3100.
- Flush in the same cycle as rvalid and out_ready=1 with count=1 → next cycle out_valid=0, count=0, state IDLE.
- Push and pop in the same cycle at count=1 → count stays 1, head advances to the newer pc.
- FETCH_ALIGN_CHECK_EN defined, pc_in=32'h3002 → no imem_req; next cycle out_valid=1, out_exc=1, out_pc=32'h3002, out_instr=0. Undefined: imem_req=1 with imem_addr=32'h3002.
